// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, instruction encodings, control FSM states
// and datapath select encodings used by the control unit, ALU and datapath registers.
package cpu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned STATE_W    = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_STEP = 2'd2;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  localparam logic WB_ALUOUT = 1'b0;
  localparam logic WB_MDR    = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_ACC  = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational map from opcode/funct3/funct7 to the instruction class that
// steers the DECODE transition; anything outside the supported subset is illegal.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_e iclass_c
);

  always_comb begin
    iclass_c = CLS_ILLEGAL;
    case (opcode)
      OP_R:      if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) iclass_c = CLS_R;
      OP_I:      if (funct3 == F3_ADD)  iclass_c = CLS_I;
      OP_LOAD:   if (funct3 == F3_WORD) iclass_c = CLS_LOAD;
      OP_STORE:  if (funct3 == F3_WORD) iclass_c = CLS_STORE;
      OP_BRANCH: if (funct3 == F3_BEQ)  iclass_c = CLS_BRANCH;
      default:   iclass_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and counts retired instructions.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_sel,
  output logic             aluout_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  state_e       state, next_state;
  instr_class_e iclass_c;
  logic         retire_c;
  logic         is_store_c;
  logic         unused_c;

  // PC_STEP is applied by the datapath; only the operand select lives here.
  assign unused_c   = ^{32'(PC_STEP), instr[29:25], instr[24:15], instr[11:7]};
  assign is_store_c = (instr[6:0] == OP_STORE);
  assign state_o    = state;

  cpu_instr_decode u_decode (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7   (instr[31:25]),
    .iclass_c (iclass_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_TRAP) illegal <= 1'b1;
      if (retire_c) instret <= instret + CNT_W'(1);
    end
  end

  // Next-state and datapath controls; every output defaults to idle values.
  always_comb begin
    next_state   = state;
    retire_c     = 1'b0;
    alu_ctrl     = ALU_ADD;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    imm_sel      = IMM_I;
    aluout_we    = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALUOUT;
    case (state)
      ST_IDLE: next_state = ST_FETCH;
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_STEP;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_sel   = IMM_B;
        aluout_we = 1'b1;
        case (iclass_c)
          CLS_R:               next_state = ST_EXEC_R;
          CLS_I:               next_state = ST_EXEC_I;
          CLS_LOAD, CLS_STORE: next_state = ST_MEM_ADDR;
          CLS_BRANCH:          next_state = ST_BRANCH;
          default:             next_state = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_ctrl   = instr[30] ? ALU_SUB : ALU_ADD;
        aluout_we  = 1'b1;
        next_state = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_b  = SRC_B_IMM;
        aluout_we  = 1'b1;
        next_state = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        rf_we      = 1'b1;
        retire_c   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_b  = SRC_B_IMM;
        imm_sel    = is_store_c ? IMM_S : IMM_I;
        aluout_we  = 1'b1;
        next_state = ST_MEM_ACC;
      end
      ST_MEM_ACC: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store_c;
        if (mem_ready) begin
          retire_c   = is_store_c;
          next_state = is_store_c ? ST_FETCH : ST_WB_MEM;
        end
      end
      ST_WB_MEM: begin
        rf_we      = 1'b1;
        wb_sel     = WB_MDR;
        retire_c   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_ctrl   = ALU_SUB;
        pc_we      = zero;
        pc_src     = zero;
        retire_c   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_TRAP: next_state = ST_TRAP;
      default: next_state = ST_IDLE;
    endcase
  end

endmodule
